// File: rtl/gf180mcu_fd_sc_mcu7t5v0__clkdiv_prog.sv
// Programmable integer clock divider feeding a clkbuf I pin.
// Ratio changes and start/stop act only at period boundaries, so the output never produces a runt pulse.
module gf180mcu_fd_sc_mcu7t5v0__clkdiv_prog #(
    parameter int WIDTH     = 8,
    parameter int RESET_DIV = 2
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             EN,
    input  logic [WIDTH-1:0] DIV,
    input  logic             DIV_REQ,
    output logic             DIV_ACK,
    output logic             Z,
    output logic             STOPPED,
    inout  wire              VDD,
    inout  wire              VSS
);

    localparam int               RST_DIV_EFF = (RESET_DIV < 2) ? 2 : RESET_DIV;
    localparam logic [WIDTH-1:0] RST_DIV_V   = RST_DIV_EFF[WIDTH-1:0];

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_next;
    logic [WIDTH-1:0] cur_div;
    logic [WIDTH-1:0] div_next;
    logic [WIDTH-1:0] div_eff;
    logic             z_q;
    logic             z_next;
    logic             ack_q;
    logic             ack_next;
    logic             boundary;
    logic             take;

    // Supply pins carry no logic; tie them into a sink so they are not flagged as unused.
    wire unused_supply = VDD ^ VSS;

    assign div_eff = (DIV < WIDTH'(2)) ? WIDTH'(2) : DIV;

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state   <= ST_STOP;
            cnt     <= '0;
            cur_div <= RST_DIV_V;
            z_q     <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            cur_div <= div_next;
            z_q     <= z_next;
            ack_q   <= ack_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        boundary   = (state == ST_STOP) || (cnt == cur_div - WIDTH'(1));
        // A request still high during its own ACK cycle must not be taken twice.
        take       = boundary && DIV_REQ && !ack_q;
        div_next   = take ? div_eff : cur_div;
        ack_next   = take;
        case (state)
            ST_STOP: begin
                cnt_next = '0;
                if (EN) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (boundary) begin
                    cnt_next = '0;
                    if (!EN) state_next = ST_STOP;
                end else begin
                    cnt_next = cnt + WIDTH'(1);
                end
            end
            default: begin
                state_next = ST_STOP;
                cnt_next   = '0;
            end
        endcase
        // High phase length comes from the ratio in force next cycle, so a new ratio shapes its first period.
        z_next = (state_next == ST_RUN) && (cnt_next < (div_next >> 1));
    end

    always_comb begin
        Z       = z_q;
        DIV_ACK = ack_q;
        STOPPED = (state == ST_STOP);
    end

endmodule
